// File: rtl/prbs16_checker.sv
// prbs16_checker: receive-side checker for the 16-bit toggle-LFSR word generator.
// Self-synchronises by reseeding from every received word, locks after a run of
// correct predictions, then free-runs its predictor and counts errored words.
module prbs16_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 8,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             err_clear,
    output logic             locked,
    output logic             match,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        pred_q, pred_d;
    logic               pred_ok_q, pred_ok_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               locked_q, locked_d;
    logic               match_q, match_d;
    logic               pulse_q, pulse_d;
    logic [RUN_W-1:0]   run_inc;

    // Generator step: bit i toggles when bit i-1 is set, bit 0 toggles on x[15]^x[14].
    function automatic logic [15:0] next_word(input logic [15:0] x);
        return x ^ {x[14:0], x[15] ^ x[14]};
    endfunction

    assign run_inc = run_q + RUN_W'(1);

    // Next-state logic: reseed-and-compare in SEARCH, flywheel prediction in LOCKED.
    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        pred_ok_d = pred_ok_q;
        run_d     = run_q;
        err_d     = err_q;
        locked_d  = locked_q;
        match_d   = 1'b0;
        pulse_d   = 1'b0;

        if (data_valid) begin
            case (state_q)
                SEARCH: begin
                    match_d   = pred_ok_q && (data_in == pred_q) && (data_in != 16'h0000);
                    pred_d    = next_word(data_in);
                    pred_ok_d = (data_in != 16'h0000);
                    if (match_d) begin
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            run_d    = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d  = next_word(pred_q);
                    match_d = (data_in == pred_q);
                    if (match_d) begin
                        run_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (run_inc == RUN_W'(UNLOCK_COUNT)) begin
                            state_d   = SEARCH;
                            locked_d  = 1'b0;
                            pred_ok_d = 1'b0;
                            run_d     = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        if (err_clear) begin
            err_d = '0;
        end
    end

    // State and registered outputs, cleared asynchronously so lock drops at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= SEARCH;
            pred_q    <= '0;
            pred_ok_q <= 1'b0;
            run_q     <= '0;
            err_q     <= '0;
            locked_q  <= 1'b0;
            match_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            pred_ok_q <= pred_ok_d;
            run_q     <= run_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            match_q   <= match_d;
            pulse_q   <= pulse_d;
        end
    end

    assign locked    = locked_q;
    assign match     = match_q;
    assign err_pulse = pulse_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: a default instance and a 4-bit error counter
// instance share the same stimulus; a behavioural model feeds a scoreboard.
module tb_prbs16_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] data_in;
    logic        data_valid;
    logic        err_clear;

    logic        locked, match, err_pulse;
    logic [15:0] err_count;
    logic        locked4, match4, err_pulse4;
    logic [3:0]  err_count4;

    typedef struct packed {
        logic        lk;
        logic        m;
        logic        p;
        logic [15:0] e;
        logic        lk4;
        logic        m4;
        logic        p4;
        logic [3:0]  e4;
    } obs_t;

    obs_t expQ[$];

    int checks = 0;
    int errors = 0;

    // model state
    logic        mLocked;
    logic        mPredOk;
    logic [15:0] mPred;
    int          mRun;
    int          mErr;
    int          mErr4;
    logic [15:0] genWord;

    always #5 clk = ~clk;

    prbs16_checker dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clear  (err_clear),
        .locked     (locked),
        .match      (match),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    prbs16_checker #(.ERR_W(4)) dut4 (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_clear  (err_clear),
        .locked     (locked4),
        .match      (match4),
        .err_pulse  (err_pulse4),
        .err_count  (err_count4)
    );

    function automatic logic [15:0] genNext(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 1; i < 16; i++) y[i] = x[i] ^ x[i-1];
        y[0] = x[0] ^ x[15] ^ x[14];
        return y;
    endfunction

    function automatic obs_t observed();
        return {locked, match, err_pulse, err_count, locked4, match4, err_pulse4, err_count4};
    endfunction

    task automatic modelReset();
        mLocked = 1'b0;
        mPredOk = 1'b0;
        mPred   = 16'h0000;
        mRun    = 0;
        mErr    = 0;
        mErr4   = 0;
        genWord = 16'h0001;
        expQ.delete();
    endtask

    // Drive one cycle, push the model's expected outputs, and advance past the edge.
    task automatic step(input logic [15:0] w, input logic v, input logic clr);
        obs_t e;
        logic m;
        logic p;
        m = 1'b0;
        p = 1'b0;
        if (v) begin
            if (!mLocked) begin
                m = mPredOk && (w == mPred) && (w != 16'h0000);
                mPred   = genNext(w);
                mPredOk = (w != 16'h0000);
                if (m) begin
                    mRun++;
                    if (mRun == 4) begin
                        mLocked = 1'b1;
                        mRun    = 0;
                    end
                end else begin
                    mRun = 0;
                end
            end else begin
                m = (w == mPred);
                mPred = genNext(mPred);
                if (m) begin
                    mRun = 0;
                end else begin
                    p = 1'b1;
                    if (mErr < 65535) mErr++;
                    if (mErr4 < 15) mErr4++;
                    mRun++;
                    if (mRun == 8) begin
                        mLocked = 1'b0;
                        mPredOk = 1'b0;
                        mRun    = 0;
                    end
                end
            end
        end
        if (clr) begin
            mErr  = 0;
            mErr4 = 0;
        end
        e.lk  = mLocked;
        e.m   = m;
        e.p   = p;
        e.e   = 16'(mErr);
        e.lk4 = mLocked;
        e.m4  = m;
        e.p4  = p;
        e.e4  = 4'(mErr4);
        expQ.push_back(e);
        data_in    = w;
        data_valid = v;
        err_clear  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        resetn     = 1'b0;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        err_clear  = 1'b0;
        modelReset();
        #12;
        o = observed();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0", o);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        logic [15:0] words [5];
        obs_t ex;
        obs_t o;
        words = '{16'h0001, 16'h0003, 16'h0005, 16'h000F, 16'h0011};
        for (int i = 0; i < 5; i++) begin
            step(words[i], 1'b1, 1'b0);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL lock_word%0d: got %h expected %h", i, o, ex);
            end
        end
        genWord = 16'h0033;
        checks++;
        if (locked !== 1'b1 || match !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL lock_final: got lk=%b m=%b err=%0d expected lk=1 m=1 err=0",
                     locked, match, err_count);
        end
    endtask

    task automatic test_flywheel();
        obs_t ex;
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                step(16'h0034, 1'b1, 1'b0);
                genWord = genNext(genWord);
            end else if (i == 1) begin
                step(16'h0000, 1'b0, 1'b0);
            end else begin
                step(genWord, 1'b1, 1'b0);
                genWord = genNext(genWord);
            end
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL flywheel_cycle%0d: got %h expected %h", i, o, ex);
            end
        end
        checks++;
        if (locked !== 1'b1 || match !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL flywheel_final: got lk=%b m=%b err=%0d expected lk=1 m=1 err=1",
                     locked, match, err_count);
        end
    endtask

    task automatic test_unlock();
        obs_t ex;
        obs_t o;
        step(16'h0000, 1'b0, 1'b1);
        ex = expQ.pop_front();
        o  = observed();
        checks++;
        if (o !== ex) begin
            errors++;
            $display("[TB] FAIL unlock_clear: got %h expected %h", o, ex);
        end
        for (int i = 0; i < 8; i++) begin
            step(16'hAAAA, 1'b1, 1'b0);
            genWord = genNext(genWord);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL unlock_garbage%0d: got %h expected %h", i, o, ex);
            end
            if (i == 6) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL unlock_7th: got lk=%b expected 1", locked);
                end
            end
        end
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd8) begin
            errors++;
            $display("[TB] FAIL unlock_8th: got lk=%b err=%0d expected lk=0 err=8", locked, err_count);
        end
        for (int i = 0; i < 5; i++) begin
            step(genWord, 1'b1, 1'b0);
            genWord = genNext(genWord);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL relock_word%0d: got %h expected %h", i, o, ex);
            end
        end
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd8) begin
            errors++;
            $display("[TB] FAIL relock_final: got lk=%b err=%0d expected lk=1 err=8", locked, err_count);
        end
    endtask

    task automatic test_zero_seed();
        logic [15:0] words [7];
        obs_t ex;
        obs_t o;
        resetn = 1'b0;
        data_valid = 1'b0;
        #3;
        resetn = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        words = '{16'h0000, 16'h0000, 16'h0001, 16'h0003, 16'h0005, 16'h000F, 16'h0011};
        for (int i = 0; i < 7; i++) begin
            step(words[i], 1'b1, 1'b0);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL zero_word%0d: got %h expected %h", i, o, ex);
            end
        end
        genWord = 16'h0033;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_lock: got lk=%b expected 1", locked);
        end
    endtask

    task automatic test_saturation();
        obs_t ex;
        obs_t o;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(genWord ^ 16'h0100, 1'b1, 1'b0);
            else            step(genWord, 1'b1, 1'b0);
            genWord = genNext(genWord);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL sat_cycle%0d: got %h expected %h", i, o, ex);
            end
        end
        checks++;
        if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_final: got e4=%0d e16=%0d lk=%b expected e4=15 e16=20 lk=1",
                     err_count4, err_count, locked);
        end
        step(genWord ^ 16'h0001, 1'b1, 1'b1);
        genWord = genNext(genWord);
        ex = expQ.pop_front();
        o  = observed();
        checks++;
        if (o !== ex) begin
            errors++;
            $display("[TB] FAIL clear_on_error: got %h expected %h", o, ex);
        end
        checks++;
        if (err_count !== 16'd0 || err_count4 !== 4'd0 || err_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_wins: got e16=%0d e4=%0d p=%b expected 0 0 1",
                     err_count, err_count4, err_pulse);
        end
    endtask

    task automatic test_async_reset();
        obs_t ex;
        obs_t o;
        step(genWord ^ 16'h0040, 1'b1, 1'b0);
        genWord = genNext(genWord);
        ex = expQ.pop_front();
        o  = observed();
        checks++;
        if (o !== ex) begin
            errors++;
            $display("[TB] FAIL pre_reset: got %h expected %h", o, ex);
        end
        data_in    = genWord;
        data_valid = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        o = observed();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", o);
        end
        data_valid = 1'b0;
        #2;
        resetn = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            step(genWord, 1'b1, 1'b0);
            genWord = genNext(genWord);
            ex = expQ.pop_front();
            o  = observed();
            checks++;
            if (o !== ex) begin
                errors++;
                $display("[TB] FAIL post_reset_word%0d: got %h expected %h", i, o, ex);
            end
            if (i == 3) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_lock: got lk=%b expected 0", locked);
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_lock: got lk=%b err=%0d expected lk=1 err=0", locked, err_count);
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_unlock();
        test_zero_seed();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
Receive-side checker for the team's 16-bit toggle-LFSR pseudo-random word generator.
- Accepts the generator's word stream, self-synchronises to it, and declares lock.
- Counts word errors once locked; drops lock on sustained mismatch.
- Sits at the far end of a datapath or link under test and reports integrity status to the control processor.

Parameters:
LOCK_COUNT, 4, consecutive matching words (after seeding) required to enter LOCKED
UNLOCK_COUNT, 8, consecutive mismatching words in LOCKED that force return to SEARCH
ERR_W, 16, width of the saturating error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  reset, asynchronous, active-low
data_in  input  16  received generator word
data_valid  input  1  data_in is valid this cycle; state advances only on valid cycles
err_clear  input  1  synchronous clear of err_count
locked  output  1  checker is in LOCKED state
match  output  1  last valid word equalled prediction (registered)
err_pulse  output  1  one-cycle pulse: last valid word was an error while LOCKED
err_count  output  ERR_W  saturating count of errored words while LOCKED

Behaviour:
- Next-word function f(x) = x XOR {x[14:0], x[15]^x[14]}, i.e. bit i toggles when bit i-1 is 1; bit 0 toggles when x[15]^x[14] is 1. Generator reset word is 0x0001. Sequence: 0001, 0003, 0005, 000F, 0011, 0033, ...
- Internal state: pred[15:0], pred_ok, state {SEARCH, LOCKED}, run_cnt (wide enough for max(LOCK_COUNT, UNLOCK_COUNT)), err_count.
- Reset (resetn low, asynchronous): state=SEARCH, pred=0, pred_ok=0, run_cnt=0, locked=0, match=0, err_pulse=0, err_count=0. Reset mid-stream discards lock immediately.
- Cycles with data_valid=0: no state change; match and err_pulse go to 0.
- All outputs are registered. Response appears the cycle after the valid word is sampled.
- SEARCH, valid word:
  - match = pred_ok & (data_in == pred) & (data_in != 0).
  - If match: run_cnt+1; when it reaches LOCK_COUNT, go to LOCKED, run_cnt=0, locked=1. Else run_cnt=0.
  - pred <= f(data_in) (reseed every word). pred_ok <= (data_in != 0).
  - 0x0000 is the lock-up word: it never matches and clears pred_ok.
  - err_count is never incremented in SEARCH.
- LOCKED, valid word:
  - Flywheel: pred <= f(pred) regardless of data_in, so a corrupted word does not corrupt later predictions.
  - match = (data_in == pred); run_cnt=0 on match.
  - Mismatch: err_pulse=1, err_count+1 (saturates at all-ones), run_cnt+1.
  - When run_cnt reaches UNLOCK_COUNT: go to SEARCH, locked=0, pred_ok=0, run_cnt=0. err_count is retained.
- err_clear: err_count=0 next cycle. If it coincides with an error increment, clear wins (result 0). err_pulse is unaffected.
- Wrap-around: the generator period is not assumed. Prediction is purely local, so the sequence wraps seamlessly.

Test Plan:
- Reset then valid words 0001,0003,0005,000F,0011 -> match=0,1,1,1,1; locked=1 the cycle after 0011; err_count=0.
- Locked stream, 0033 replaced by 0034, then 00?? correct words continue -> single err_pulse, err_count=1, match returns 1 on the next word; locked stays 1 (flywheel).
- Locked, then 8 consecutive garbage words (e.g. 0xAAAA each) -> err_count=8; locked=0 after the 8th; then a correct 5-word run relocks, err_count stays 8.
- Stream containing 0000,0000,0001,0003,... in SEARCH -> no match on zeros; lock after 0001 seed plus 4 matches.
- Saturation with ERR_W=4 -> 20 errors while locked give err_count=15. err_clear asserted on an error cycle -> err_count=0.
- Assert resetn low asynchronously mid-LOCKED (between clock edges) -> locked, match, err_pulse, err_count all 0 immediately; relock requires the full seed plus LOCK_COUNT sequence.
